// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencing controller for the matrix-multiplier datapath.
// After a start request it clears the PE accumulators, runs the skewed
// systolic feed for a fixed number of steps, then walks result matrix C in
// row-major order and writes every element to the selected scratchpad target.
// In bias mode each element is read back first so that the datapath can add
// the old content. A one-cycle done/flags_we pulse ends the operation.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  one-cycle start request (ignored while busy)
//   dim_n_i, dim_k_i,        matrix dimensions minus 1 (dim_k_i only goes to
//   dim_m_i                  the datapath and is not used here)
//   write_target_i           scratchpad target for C
//   bias_en_i                C := A*B + old scratchpad content
//   busy_o, done_o           operation in progress / completion pulse
//   pe_clr_o, pe_en_o        PE accumulator clear / systolic step enable
//   step_o                   feed step index for operand skew
//   res_row_o, res_col_o     PE result select
//   sp_re_o, sp_we_o         scratchpad read / write strobes
//   sp_addr_o, sp_target_o   scratchpad element address and target
//   add_bias_o               datapath adds scratchpad read data to result
//   flags_we_o               latch PE overflow flags into FLAGS
module matmul_ctrl #(
  parameter int  BUS_WIDTH   = 32,
  parameter int  DATA_WIDTH  = 8,
  parameter int  ADDR_WIDTH  = 16,
  parameter int  SP_NTARGETS = 4,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int DW          = $clog2(MAX_DIM),
  localparam int TW          = $clog2(SP_NTARGETS),
  localparam int SW          = $clog2(3 * MAX_DIM)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DW-1:0]         dim_n_i,
  input  logic [DW-1:0]         dim_k_i,
  input  logic [DW-1:0]         dim_m_i,
  input  logic [TW-1:0]         write_target_i,
  input  logic                  bias_en_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pe_clr_o,
  output logic                  pe_en_o,
  output logic [SW-1:0]         step_o,
  output logic [DW-1:0]         res_row_o,
  output logic [DW-1:0]         res_col_o,
  output logic                  sp_re_o,
  output logic                  sp_we_o,
  output logic [ADDR_WIDTH-1:0] sp_addr_o,
  output logic [TW-1:0]         sp_target_o,
  output logic                  add_bias_o,
  output logic                  flags_we_o
);

  // The feed always runs the full skew length of a MAX_DIM array so that
  // partial-size operands still drain completely.
  localparam int LAST_STEP = 3 * MAX_DIM - 3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COMPUTE, S_BRD, S_WR, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         step_q, step_d;
  logic [DW-1:0]         row_q, row_d, col_q, col_d;
  logic [DW-1:0]         n_q, n_d, m_q, m_d;
  logic [TW-1:0]         tgt_q, tgt_d;
  logic                  bias_q, bias_d;

  logic                  busy_q, busy_d, done_q, done_d;
  logic                  pe_clr_q, pe_clr_d, pe_en_q, pe_en_d;
  logic                  sp_re_q, sp_re_d, sp_we_q, sp_we_d;
  logic [ADDR_WIDTH-1:0] sp_addr_q, sp_addr_d;
  logic [TW-1:0]         sp_target_q, sp_target_d;
  logic                  add_bias_q, add_bias_d;
  logic                  sp_phase;

  logic                  unused_dim_k;
  assign unused_dim_k = ^dim_k_i;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    row_d   = row_q;
    col_d   = col_q;
    n_d     = n_q;
    m_d     = m_q;
    tgt_d   = tgt_q;
    bias_d  = bias_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d     = dim_n_i;
          m_d     = dim_m_i;
          tgt_d   = write_target_i;
          bias_d  = bias_en_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        step_d  = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (step_q == SW'(LAST_STEP)) begin
          step_d  = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = bias_q ? S_BRD : S_WR;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      S_BRD: begin
        state_d = S_WR;
      end
      S_WR: begin
        if (row_q == n_q && col_q == m_q) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_DONE;
        end else begin
          if (col_q == m_q) begin
            col_d = '0;
            row_d = row_q + DW'(1);
          end else begin
            col_d = col_q + DW'(1);
          end
          state_d = bias_q ? S_BRD : S_WR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered in
    // the same cycle as the state they belong to. Row/col and step counters
    // are held at zero outside their phases, so they drive outputs directly.
    sp_phase    = (state_d == S_BRD) || (state_d == S_WR);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    pe_clr_d    = (state_d == S_CLEAR);
    pe_en_d     = (state_d == S_COMPUTE);
    sp_re_d     = (state_d == S_BRD);
    sp_we_d     = (state_d == S_WR);
    add_bias_d  = (state_d == S_WR) && bias_d;
    sp_target_d = sp_phase ? tgt_d : '0;
    sp_addr_d   = sp_phase ? (ADDR_WIDTH'(row_d) * ADDR_WIDTH'(MAX_DIM)
                              + ADDR_WIDTH'(col_d)) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      n_q         <= '0;
      m_q         <= '0;
      tgt_q       <= '0;
      bias_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_clr_q    <= 1'b0;
      pe_en_q     <= 1'b0;
      sp_re_q     <= 1'b0;
      sp_we_q     <= 1'b0;
      sp_addr_q   <= '0;
      sp_target_q <= '0;
      add_bias_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      row_q       <= row_d;
      col_q       <= col_d;
      n_q         <= n_d;
      m_q         <= m_d;
      tgt_q       <= tgt_d;
      bias_q      <= bias_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pe_clr_q    <= pe_clr_d;
      pe_en_q     <= pe_en_d;
      sp_re_q     <= sp_re_d;
      sp_we_q     <= sp_we_d;
      sp_addr_q   <= sp_addr_d;
      sp_target_q <= sp_target_d;
      add_bias_q  <= add_bias_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign flags_we_o  = done_q;
  assign pe_clr_o    = pe_clr_q;
  assign pe_en_o     = pe_en_q;
  assign step_o      = step_q;
  assign res_row_o   = row_q;
  assign res_col_o   = col_q;
  assign sp_re_o     = sp_re_q;
  assign sp_we_o     = sp_we_q;
  assign sp_addr_o   = sp_addr_q;
  assign sp_target_o = sp_target_q;
  assign add_bias_o  = add_bias_q;

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencing controller for the matrix-multiplier datapath. It accepts a start pulse and operand dimensions from the APB register file, then drives three phases: clear the processing-element (PE) accumulators, run the skewed systolic feed, and write result matrix C into a selected scratchpad target. Optionally each element is read back first so the datapath can add it as a bias. At the end it pulses done and commits the overflow flags, which is the point at which software (and the golden checker) reads C and FLAGS over APB.

## Interface
- BUS_WIDTH, 32, APB/operand bus width.
- DATA_WIDTH, 8, operand element width.
- ADDR_WIDTH, 16, scratchpad address width.
- SP_NTARGETS, 4, number of scratchpad targets.
- Derived localparams: MAX_DIM = BUS_WIDTH/DATA_WIDTH; DW = $clog2(MAX_DIM); TW = $clog2(SP_NTARGETS); SW = $clog2(3·MAX_DIM).
- Clock: one clock, `clk_i`.
- Reset: asynchronous, active-low, `rst_ni`.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  async active-low reset.
- start_i  in  1  one-cycle start request (CONTROL.START write).
- dim_n_i  in  DW  rows of A minus 1.
- dim_k_i  in  DW  shared dimension minus 1. Passed through to the datapath only.
- dim_m_i  in  DW  columns of B minus 1.
- write_target_i  in  TW  scratchpad target for C.
- bias_en_i  in  1  C := A·B + old scratchpad content.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- pe_clr_o  out  1  clear PE accumulators and flag bits.
- pe_en_o  out  1  advance systolic array one step.
- step_o  out  SW  feed step index. The datapath uses it for operand skew.
- res_row_o, res_col_o  out  DW each  PE result select.
- sp_re_o, sp_we_o  out  1 each  scratchpad read / write strobe.
- sp_addr_o  out  ADDR_WIDTH  scratchpad element address.
- sp_target_o  out  TW  scratchpad target.
- add_bias_o  out  1  datapath adds sp read data to the selected result.
- flags_we_o  out  1  latch PE overflow flags into FLAGS register.

## Operation
- States: IDLE, CLEAR, COMPUTE, BRD, WR, DONE.
- Reset: all outputs 0, state IDLE, all counters 0.
- IDLE:
  - start_i=1 latches dim_n_i, dim_m_i, write_target_i and bias_en_i, then goes to CLEAR.
  - start_i is ignored in every other state. No queuing.
- CLEAR: pe_clr_o=1 for 1 cycle, then COMPUTE.
- COMPUTE:
  - Lasts exactly 3·MAX_DIM−2 cycles, independent of the dims.
  - pe_en_o=1 throughout; step_o counts 0 … 3·MAX_DIM−3.
  - Then go to BRD if bias, else WR, with row=col=0.
- Element iteration:
  - Row-major: col 0…dim_m, then row++, up to row dim_n.
  - E = (dim_n+1)(dim_m+1) elements.
  - sp_addr_o = row·MAX_DIM + col (zero-extended); sp_target_o = latched target.
  - res_row_o / res_col_o = row / col.
- BRD (bias only): sp_re_o=1 for 1 cycle, then WR with the same element.
- WR:
  - sp_we_o=1.
  - add_bias_o = latched bias_en.
  - Last element goes to DONE. Otherwise advance the element and go to BRD (bias) or stay in WR.
- DONE: done_o=1 and flags_we_o=1 for 1 cycle, then IDLE.
- Outside their states: sp_addr_o, step_o, res_row_o and res_col_o are 0; all strobes are 0.
- busy_o=1 in every state except IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No write is completed and no done pulse is produced.

## Timing
- Cycle 0 is the cycle in which start_i=1 is sampled in IDLE.
- CLEAR occupies cycle 1.
- COMPUTE occupies cycles 2 … 3·MAX_DIM−1.
- Write phase: w = 2 with bias, 1 without. It occupies cycles 3·MAX_DIM … 3·MAX_DIM + E·w − 1.
- DONE occurs at cycle 3·MAX_DIM + E·w.
- busy_o rises at cycle 1 and is 0 again in the cycle after DONE.
- A new start_i is accepted from the first IDLE cycle onward.
- Bias mode: scratchpad read latency is 1 cycle. Data requested in BRD is valid during the following WR.
- All outputs are registered or decoded from registered state only. There are no combinational paths from start_i.

## Test plan
- Full 4×4, no bias (defaults; dims n=m=3):
  - Required: pe_clr_o at cycle 1; pe_en_o cycles 2–11 with step 0–9; sp_we_o cycles 12–27, addresses 0…15, target 2.
  - Required: done_o and flags_we_o at cycle 28.
- 2×3, no bias (n=1, m=2):
  - Required: writes to addresses 0, 1, 2, 4, 5, 6 in cycles 12–17; done_o at cycle 18.
- 2×2 with bias:
  - Required: alternating sp_re_o / sp_we_o over cycles 12–19 on addresses 0, 0, 1, 1, 4, 4, 5, 5; add_bias_o=1 on every WR; done_o at cycle 20.
- start_i pulsed again during COMPUTE and during WR:
  - Required: ignored; the sequence and done timing are identical to the first scenario.
- rst_ni low at cycle 15 of a 4×4 run:
  - Required: all outputs 0 immediately and state IDLE.
  - Required: the next start gives done_o 28 cycles later.
- Back-to-back operations, start_i in the first IDLE cycle after DONE:
  - Required: two done pulses 29 cycles apart; busy_o low for exactly that one IDLE cycle.
